// File: rtl/recur_engine.sv
// recur_engine: iterative datapath accelerator computing y(k) = C*y(k-1) + X,
// with y(0) = 0, for N iterations. C, X and N are latched on an accepted start.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - asynchronous active-low reset
//   en     - iteration enable; 0 stalls RUN with all state held
//   start  - start request, accepted in IDLE or DONE only
//   n_iter - iteration count N (latched on start)
//   coef   - unsigned coefficient C (latched on start)
//   x      - unsigned additive input X (latched on start)
//   busy   - high while running
//   done   - one-cycle pulse, result valid on y
//   ovf    - sticky overflow flag for the current run
//   y      - result register, updated every iteration
//
// Build option: define RECUR_SAT_EN to saturate y to all-ones on overflow
// instead of wrapping modulo 2^W.
module recur_engine #(
    parameter int unsigned W     = 32,
    parameter int unsigned C_W   = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] n_iter,
    input  logic [C_W-1:0]   coef,
    input  logic [W-1:0]     x,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [W-1:0]     y
);

    // Product plus one carry bit for the addition of X.
    localparam int unsigned P_W = W + C_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] n_q;
    logic [C_W-1:0]   c_q;
    logic [W-1:0]     x_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [W-1:0]     y_nxt;
    logic             ovf_nxt;
    logic             load;
    logic [P_W-1:0]   p;
    logic             p_ovf;
    logic [W-1:0]     step_y;

    // One recurrence step on the current y.
    always_comb begin
        p     = P_W'(c_q) * P_W'(y) + P_W'(x_q);
        p_ovf = |p[P_W-1:W];
`ifdef RECUR_SAT_EN
        step_y = p_ovf ? {W{1'b1}} : p[W-1:0];
`else
        step_y = p[W-1:0];
`endif
    end

    // Next-state and datapath control. After the N-th iteration the engine
    // spends one more enabled RUN cycle (cnt == N) before entering DONE, so
    // N == 0 leaves RUN on its first edge without iterating.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        y_nxt     = y;
        ovf_nxt   = ovf;
        load      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    y_nxt     = '0;
                    ovf_nxt   = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (n_q == '0) begin
                    state_nxt = DONE;
                end else if (en) begin
                    if (cnt == n_q) begin
                        state_nxt = DONE;
                    end else begin
                        y_nxt   = step_y;
                        cnt_nxt = cnt + CNT_W'(1);
                        ovf_nxt = ovf | p_ovf;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            y     <= '0;
            ovf   <= 1'b0;
            n_q   <= '0;
            c_q   <= '0;
            x_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            y     <= y_nxt;
            ovf   <= ovf_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
            if (load) begin
                n_q <= n_iter;
                c_q <= coef;
                x_q <= x;
            end
        end
    end

endmodule

// File: tb/tb_recur_engine.sv
// Self-checking bench for recur_engine: directed scenarios plus randomized
// runs compared against an arithmetic reference model of the recurrence.
module tb_recur_engine;

    localparam int unsigned W     = 32;
    localparam int unsigned C_W   = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned W8    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             start;
    logic [CNT_W-1:0] n_iter;
    logic [C_W-1:0]   coef;
    logic [W-1:0]     x;
    logic             busy, done, ovf;
    logic [W-1:0]     y;

    logic             start8;
    logic [CNT_W-1:0] n8;
    logic [C_W-1:0]   c8;
    logic [W8-1:0]    x8;
    logic             busy8, done8, ovf8;
    logic [W8-1:0]    y8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    recur_engine #(.W(W), .C_W(C_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .n_iter(n_iter),
        .coef(coef), .x(x), .busy(busy), .done(done), .ovf(ovf), .y(y)
    );

    recur_engine #(.W(W8), .C_W(C_W), .CNT_W(CNT_W)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .start(start8), .n_iter(n8),
        .coef(c8), .x(x8), .busy(busy8), .done(done8), .ovf(ovf8), .y(y8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: one step of y = C*y + X on unbounded integers, then reduced to w bits.
    function automatic longint unsigned ref_step(input longint unsigned yv, input longint unsigned c,
                                                 input longint unsigned xv, input int w, output bit of);
        longint unsigned lim;
        longint unsigned p;
        lim = 64'd1 << w;
        p   = c * yv + xv;
        of  = (p >= lim);
`ifdef RECUR_SAT_EN
        return of ? lim - 1 : p;
`else
        return p % lim;
`endif
    endfunction

    // One run on the 32-bit instance. Stall of stall_len cycles once iter==stall_at;
    // a foreign start pulse is injected at cycle restart_at (negative = none).
    // Returns at the DONE cycle (sampled just after its edge).
    task automatic do_run(input int n, input longint unsigned c, input longint unsigned xv,
                          input int stall_at, input int stall_len, input int restart_at,
                          input string tag, output longint unsigned fy, output int fcyc);
        longint unsigned ey = 0;
        bit eovf = 0;
        bit of;
        bit en_now;
        bit got_done = 0;
        int iter = 0;
        int stalls = 0;
        int cyc = 0;
        @(negedge clk);
        start = 1'b1; n_iter = CNT_W'(n); coef = C_W'(c); x = W'(xv); en = 1'b1;
        @(posedge clk); #1;
        check({tag, ".start_busy"}, busy, 1);
        check({tag, ".start_y"}, y, 0);
        check({tag, ".start_ovf"}, ovf, 0);
        check({tag, ".start_done"}, done, 0);
        while (!got_done && cyc < n + stall_len + 20) begin
            @(negedge clk);
            start = (cyc == restart_at);
            if (start) begin
                coef = ~C_W'(c);
                x = W'(xv) ^ W'(32'h5555_aaaa);
                n_iter = CNT_W'(n + 3);
            end
            en_now = !(n > 0 && iter == stall_at && stalls < stall_len);
            en = en_now;
            @(posedge clk); #1;
            cyc++;
            if (!en_now) stalls++;
            else if (iter < n) begin
                ey = ref_step(ey, c, xv, W, of);
                eovf |= of;
                iter++;
            end
            got_done = done;
            check({tag, ".y"}, y, ey);
            check({tag, ".ovf"}, ovf, eovf);
            check({tag, ".busy"}, busy, (cyc < n + 1 + stalls));
            check({tag, ".done"}, done, (cyc == n + 1 + stalls));
        end
        start = 1'b0;
        en = 1'b1;
        check({tag, ".done_seen"}, got_done, 1);
        check({tag, ".latency"}, cyc, n + 1 + stalls);
        fy = ey;
        fcyc = cyc;
    endtask

    // One cycle after DONE with no start: back to idle, y held.
    task automatic idle_check(input string tag, input longint unsigned ey);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, ".idle_done"}, done, 0);
        check({tag, ".idle_busy"}, busy, 0);
        check({tag, ".idle_y"}, y, ey);
    endtask

    initial begin
        longint unsigned fy;
        longint unsigned ey8;
        int fcyc;
        int n;
        int sa;
        int sl;
        int ra;
        bit of;
        bit eovf8;
        int wait_cyc;

        rst = 1'b0; en = 1'b0; start = 1'b0; n_iter = '0; coef = '0; x = '0;
        start8 = 1'b0; n8 = '0; c8 = '0; x8 = '0;
        #1;
        check("reset.y", y, 0);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.ovf", ovf, 0);
        #20;
        @(negedge clk); rst = 1'b1; en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset.busy", busy, 0);
        check("post_reset.y", y, 0);

        // T1: C=2, X=1, N=5 -> 31, done 6 cycles after start.
        do_run(5, 2, 1, 0, 0, -1, "t1", fy, fcyc);
        check("t1.final_y", y, 31);
        check("t1.final_ovf", ovf, 0);
        check("t1.cycles", fcyc, 6);
        idle_check("t1", 31);

        // T2: N=0.
        do_run(0, 7, 9, 0, 0, -1, "t2", fy, fcyc);
        check("t2.final_y", y, 0);
        check("t2.cycles", fcyc, 1);
        idle_check("t2", 0);

        // T4: T1 with a 3-cycle stall after the 2nd iteration.
        do_run(5, 2, 1, 2, 3, -1, "t4", fy, fcyc);
        check("t4.final_y", y, 31);
        check("t4.cycles", fcyc, 9);
        idle_check("t4", 31);

        // T5: restart mid-run ignored, then back-to-back start in DONE cycle.
        do_run(5, 2, 1, 0, 0, 2, "t5a", fy, fcyc);
        check("t5a.final_y", y, 31);
        do_run(3, 3, 2, 0, 0, -1, "t5b", fy, fcyc);
        check("t5b.final_y", y, 26);
        idle_check("t5b", 26);

        // C=0 and X=0 corner cases.
        do_run(4, 0, 77, 0, 0, -1, "c0", fy, fcyc);
        check("c0.final_y", y, 77);
        check("c0.final_ovf", ovf, 0);
        idle_check("c0", 77);
        do_run(6, 200, 0, 1, 2, -1, "x0", fy, fcyc);
        check("x0.final_y", y, 0);
        check("x0.final_ovf", ovf, 0);
        idle_check("x0", 0);

        // T3 on the 8-bit instance: C=3, X=1, N=6.
        @(negedge clk);
        start8 = 1'b1; n8 = CNT_W'(6); c8 = 8'd3; x8 = 8'd1;
        @(negedge clk);
        start8 = 1'b0;
        ey8 = 0; eovf8 = 0;
        for (int i = 0; i < 6; i++) begin
            ey8 = ref_step(ey8, 3, 1, W8, of);
            eovf8 |= of;
        end
        wait_cyc = 0;
        while (!done8 && wait_cyc < 30) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        check("t3.done8", done8, 1);
        check("t3.y8_model", y8, ey8);
`ifdef RECUR_SAT_EN
        check("t3.y8", y8, 8'hff);
`else
        check("t3.y8", y8, 8'h6c);
`endif
        check("t3.ovf8", ovf8, 1);
        check("t3.ovf8_model", ovf8, eovf8);

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            n  = int'($urandom_range(0, 12));
            sa = int'($urandom_range(0, n));
            sl = (n > 0) ? int'($urandom_range(0, 3)) : 0;
            ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n)) : -1;
            do_run(n, longint'($urandom_range(0, 255)), longint'($urandom), sa, sl, ra,
                   $sformatf("rnd%0d", r), fy, fcyc);
            idle_check($sformatf("rnd%0d", r), fy);
        end

        // T6: asynchronous reset mid-run.
        @(negedge clk);
        start = 1'b1; n_iter = CNT_W'(10); coef = 8'd2; x = 32'd1; en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6.y", y, 0);
        check("t6.busy", busy, 0);
        check("t6.done", done, 0);
        check("t6.ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t6.quiet_busy", busy, 0);
            check("t6.quiet_done", done, 0);
            check("t6.quiet_y", y, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
